multu_seq: RTL and testbench

Sequential unsigned 32×32 shift-add multiplier in the EX stage of the 5-stage MIPS pipeline, downstream of the ID-stage control decoder. The decoder's `Mulrst` output, registered through ID/EX, starts an operation. The block holds architectural HI/LO, serves MFHI/MFLO reads, and raises `busy` so the hazard unit stalls dependent instructions.

---
 rtl/multu_seq.sv | 125 ++++++++++++
 tb/tb_multu_seq.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/multu_seq.sv
// Sequential unsigned WIDTHxWIDTH shift-add multiplier holding HI/LO for MFHI/MFLO.
// Optional MULTU_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are zero.
module multu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Mulrst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       rd_sel,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t               state_reg, state_next;
  logic [2*WIDTH-1:0]   mcand_reg, mcand_next;
  logic [2*WIDTH-1:0]   prod_reg, prod_next;
  logic [2*WIDTH-1:0]   prod_sum, addend;
  logic [WIDTH-1:0]     mplier_reg, mplier_next, mplier_shift;
  logic [WIDTH-1:0]     hi_reg, hi_next, lo_reg, lo_next;
  logic [CW-1:0]        cnt_reg, cnt_next;
  logic                 last_iter;

  // Partial product: the shifted multiplicand gated by the current multiplier LSB.
  genvar gi;
  generate
    for (gi = 0; gi < 2*WIDTH; gi++) begin : g_addend
      assign addend[gi] = mcand_reg[gi] & mplier_reg[0];
    end
  endgenerate

  assign prod_sum     = prod_reg + addend;
  assign mplier_shift = mplier_reg >> 1;

`ifdef MULTU_EARLY_EXIT_EN
  assign last_iter = (cnt_reg == LAST_CNT) || (mplier_shift == '0);
`else
  assign last_iter = (cnt_reg == LAST_CNT);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= S_IDLE;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      prod_reg   <= '0;
      cnt_reg    <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
    end else begin
      state_reg  <= state_next;
      mcand_reg  <= mcand_next;
      mplier_reg <= mplier_next;
      prod_reg   <= prod_next;
      cnt_reg    <= cnt_next;
      hi_reg     <= hi_next;
      lo_reg     <= lo_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    mcand_next  = mcand_reg;
    mplier_next = mplier_reg;
    prod_next   = prod_reg;
    cnt_next    = cnt_reg;
    hi_next     = hi_reg;
    lo_next     = lo_reg;
    case (state_reg)
      S_IDLE, S_DONE: begin
        if (Mulrst) begin
          mcand_next  = {{WIDTH{1'b0}}, a};
          mplier_next = b;
          prod_next   = '0;
          cnt_next    = '0;
          state_next  = S_RUN;
        end else begin
          state_next  = S_IDLE;
        end
      end
      S_RUN: begin
        // A new start aborts the running operation; HI/LO are left untouched.
        if (Mulrst) begin
          mcand_next  = {{WIDTH{1'b0}}, a};
          mplier_next = b;
          prod_next   = '0;
          cnt_next    = '0;
        end else begin
          prod_next   = prod_sum;
          mcand_next  = mcand_reg << 1;
          mplier_next = mplier_shift;
          cnt_next    = cnt_reg + CW'(1);
          if (last_iter) begin
            hi_next    = prod_sum[2*WIDTH-1:WIDTH];
            lo_next    = prod_sum[WIDTH-1:0];
            state_next = S_DONE;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    case (rd_sel)
      2'b01:   rd_data = hi_reg;
      2'b10:   rd_data = lo_reg;
      default: rd_data = '0;
    endcase
  end

  assign busy = (state_reg == S_RUN);
  assign done = (state_reg == S_DONE);
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule

// File: tb/tb_multu_seq.sv
// Directed bench for multu_seq: latency, commit, reads, abort, back-to-back and async reset.
module tb_multu_seq;
  localparam int WIDTH = 32;
`ifdef MULTU_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             Mulrst;
  logic [WIDTH-1:0] a, b;
  logic [1:0]       rd_sel;
  logic [WIDTH-1:0] rd_data;
  logic             busy, done;
  logic [WIDTH-1:0] hi, lo;

  int checks   = 0;
  int failures = 0;
  int n;

  multu_seq #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .Mulrst  (Mulrst),
    .a       (a),
    .b       (b),
    .rd_sel  (rd_sel),
    .rd_data (rd_data),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
    a      = av;
    b      = bv;
    Mulrst = 1'b1;
    tick();
    Mulrst = 1'b0;
  endtask

  // Counts cycles with busy high, bounded so a stuck DUT still reaches the summary.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (busy === 1'b1 && cyc < 200) begin
      cyc++;
      tick();
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    Mulrst = 1'b0;
    a      = '0;
    b      = '0;
    rd_sel = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_rd", 64'(rd_data), 64'd0);

    // 3 x 5
    start_op(32'd3, 32'd5);
    wait_done(n);
    check("t1_cycles", 64'(n), EARLY ? 64'd3 : 64'd32);
    check("t1_done", 64'(done), 64'd1);
    check("t1_hi", 64'(hi), 64'h0);
    check("t1_lo", 64'(lo), 64'hF);
    rd_sel = 2'b10;
    #1;
    check("t1_rd_lo", 64'(rd_data), 64'hF);
    tick();
    check("t1_done_one", 64'(done), 64'd0);

    // all-ones x all-ones
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(n);
    check("t2_cycles", 64'(n), 64'd32);
    check("t2_hi", 64'(hi), 64'hFFFF_FFFE);
    check("t2_lo", 64'(lo), 64'h1);
    rd_sel = 2'b01;
    #1;
    check("t2_rd_hi", 64'(rd_data), 64'hFFFF_FFFE);
    rd_sel = 2'b11;
    #1;
    check("t2_rd_rsv", 64'(rd_data), 64'h0);
    rd_sel = 2'b00;
    #1;
    check("t2_rd_none", 64'(rd_data), 64'h0);
    tick();

    // read of committed LO while a new operation runs
    start_op(32'd3, 32'd5);
    wait_done(n);
    tick();
    start_op(32'h0001_0000, 32'h0001_0000);
    repeat (9) tick();
    rd_sel = 2'b10;
    #1;
    check("t3_busy_mid", 64'(busy), 64'd1);
    check("t3_rd_mid", 64'(rd_data), 64'hF);
    wait_done(n);
    check("t3_cycles", 64'(9 + n), EARLY ? 64'd17 : 64'd32);
    check("t3_hi", 64'(hi), 64'h1);
    check("t3_lo", 64'(lo), 64'h0);
    tick();

    // abort 3x5 with a restart of 6x7
    start_op(32'd3, 32'd5);
    repeat (EARLY ? 1 : 11) tick();
    check("t4_busy_pre", 64'(busy), 64'd1);
    start_op(32'd6, 32'd7);
    check("t4_busy_re", 64'(busy), 64'd1);
    check("t4_hi_keep", 64'(hi), 64'h1);
    check("t4_lo_keep", 64'(lo), 64'h0);
    wait_done(n);
    check("t4_cycles", 64'(n), EARLY ? 64'd3 : 64'd32);
    check("t4_hi", 64'(hi), 64'h0);
    check("t4_lo", 64'(lo), 64'd42);
    tick();

    // 7x2 then back-to-back 5x0 started in the DONE cycle
    start_op(32'd7, 32'd2);
    wait_done(n);
    check("t6a_cycles", 64'(n), EARLY ? 64'd2 : 64'd32);
    check("t6a_done", 64'(done), 64'd1);
    check("t6a_lo", 64'(lo), 64'd14);
    start_op(32'd5, 32'd0);
    check("t6b_busy", 64'(busy), 64'd1);
    check("t6b_done_off", 64'(done), 64'd0);
    wait_done(n);
    check("t6b_cycles", 64'(n), EARLY ? 64'd1 : 64'd32);
    check("t6b_done", 64'(done), 64'd1);
    check("t6b_hi", 64'(hi), 64'h0);
    check("t6b_lo", 64'(lo), 64'h0);
    tick();
    check("t6b_done_one", 64'(done), 64'd0);

    // restore a nonzero LO, then async reset mid-run
    start_op(32'd6, 32'd7);
    wait_done(n);
    tick();
    start_op(32'h0000_FFFF, 32'h0000_FFFF);
    repeat (EARLY ? 9 : 19) tick();
    rd_sel = 2'b10;
    #1;
    check("t5_busy_pre", 64'(busy), 64'd1);
    check("t5_rd_pre", 64'(rd_data), 64'd42);
    #1;
    rst_n = 1'b0;
    #1;
    check("t5_busy_rst", 64'(busy), 64'd0);
    check("t5_done_rst", 64'(done), 64'd0);
    check("t5_hi_rst", 64'(hi), 64'h0);
    check("t5_lo_rst", 64'(lo), 64'h0);
    check("t5_rd_rst", 64'(rd_data), 64'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (40) tick();
    check("t5_busy_post", 64'(busy), 64'd0);
    check("t5_done_post", 64'(done), 64'd0);
    check("t5_hi_post", 64'(hi), 64'h0);
    check("t5_lo_post", 64'(lo), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
